// File: rtl/pwm_array_pkg.sv
// pwm_array_pkg
// Shared encodings for the PWM channel array: channel mode, config field
// select codes, per-channel FSM state, and a helper that says whether a
// mode produces output activity.
package pwm_array_pkg;

  // Channel operating mode (cfg_sel = SEL_MODE, data bits [1:0])
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_CONT  = 2'd1,
    MODE_BURST = 2'd2,
    MODE_RSVD  = 2'd3
  } pwm_mode_e;

  // Config field select
  typedef enum logic [1:0] {
    SEL_PERIOD = 2'd0,
    SEL_DUTY   = 2'd1,
    SEL_BURST  = 2'd2,
    SEL_MODE   = 2'd3
  } cfg_sel_e;

  // Per-channel FSM state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  // Width of the channel index on the config bus
  localparam int unsigned CH_IDX_W = 5;

  // Only CONTINUOUS and BURST drive the output; reserved behaves as OFF.
  function automatic logic mode_runs(input pwm_mode_e m);
    logic r;
    case (m)
      MODE_CONT, MODE_BURST: r = 1'b1;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pwm_array_chan.sv
// pwm_array_chan
// One PWM channel: shadow/active config registers, period counter,
// saturating burst counter and an IDLE/RUN FSM. The shadow set is written by
// the config bus; the active set is loaded from the shadow set (including a
// write landing in the same cycle) on start and at every period wrap.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_we/sel/wdata    shadow register write (already decoded for this channel)
//   start, stop         channel start / stop pulses (stop has priority)
//   sync_in             zero the running counter without reloading config
//   pwm_out             registered PWM output
//   busy                channel in RUN
//   done                one-cycle pulse at natural burst completion
module pwm_array_chan
  import pwm_array_pkg::*;
#(
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_sel,
  input  logic [CW-1:0] cfg_wdata,
  input  logic          start,
  input  logic          stop,
  input  logic          sync_in,
  output logic          pwm_out,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  chan_state_e   state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [CW-1:0] burst_cnt_r, burst_cnt_s;
  logic [CW-1:0] sh_period_r, sh_duty_r, sh_burst_r;
  logic [CW-1:0] sh_period_s, sh_duty_s, sh_burst_s;
  pwm_mode_e     sh_mode_r, sh_mode_s;
  logic [CW-1:0] act_period_r, act_duty_r, act_burst_r;
  logic [CW-1:0] act_period_s, act_duty_s, act_burst_s;
  pwm_mode_e     act_mode_r, act_mode_s;
  logic          pwm_r, pwm_s;
  logic          done_r, done_s;
  logic          wrap_s;
  logic          start_ok_s;
  logic [CW-1:0] burst_inc_s;

  // Shadow set including this cycle's write, so a write coinciding with
  // start or a wrap is picked up immediately.
  always_comb begin
    sh_period_s = sh_period_r;
    sh_duty_s   = sh_duty_r;
    sh_burst_s  = sh_burst_r;
    sh_mode_s   = sh_mode_r;
    if (cfg_we) begin
      case (cfg_sel)
        SEL_PERIOD: sh_period_s = cfg_wdata;
        SEL_DUTY:   sh_duty_s   = cfg_wdata;
        SEL_BURST:  sh_burst_s  = cfg_wdata;
        SEL_MODE:   sh_mode_s   = pwm_mode_e'(cfg_wdata[1:0]);
        default:    sh_mode_s   = sh_mode_r;
      endcase
    end else begin
      sh_mode_s = sh_mode_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and datapath: priority stop > start > wrap > sync > count.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    burst_cnt_s  = burst_cnt_r;
    act_period_s = act_period_r;
    act_duty_s   = act_duty_r;
    act_burst_s  = act_burst_r;
    act_mode_s   = act_mode_r;
    done_s       = 1'b0;

    wrap_s      = (state_r == ST_RUN) && (cnt_r == (act_period_r - CNT_ONE));
    // A start with period 0 or a non-running mode is ignored entirely.
    start_ok_s  = (sh_period_s != CNT_ZERO) && mode_runs(sh_mode_s);
    burst_inc_s = (burst_cnt_r == CNT_MAX) ? burst_cnt_r : (burst_cnt_r + CNT_ONE);

    if (stop) begin
      state_s     = ST_IDLE;
      cnt_s       = CNT_ZERO;
      burst_cnt_s = CNT_ZERO;
    end else if (start && start_ok_s) begin
      act_period_s = sh_period_s;
      act_duty_s   = sh_duty_s;
      act_burst_s  = sh_burst_s;
      act_mode_s   = sh_mode_s;
      cnt_s        = CNT_ZERO;
      burst_cnt_s  = CNT_ZERO;
      // Zero-length burst completes at once without ever entering RUN.
      if ((sh_mode_s == MODE_BURST) && (sh_burst_s == CNT_ZERO)) begin
        state_s = ST_IDLE;
        done_s  = 1'b1;
      end else begin
        state_s = ST_RUN;
      end
    end else if (state_r == ST_RUN) begin
      if (wrap_s) begin
        cnt_s = CNT_ZERO;
        if ((act_mode_r == MODE_BURST) && (burst_inc_s >= act_burst_r)) begin
          state_s     = ST_IDLE;
          burst_cnt_s = CNT_ZERO;
          done_s      = 1'b1;
        end else begin
          act_period_s = sh_period_s;
          act_duty_s   = sh_duty_s;
          act_burst_s  = sh_burst_s;
          act_mode_s   = sh_mode_s;
          burst_cnt_s  = burst_inc_s;
          // Reloaded config that cannot run (OFF or period 0) parks the channel.
          if (start_ok_s) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_IDLE;
          end
        end
      end else if (sync_in) begin
        cnt_s = CNT_ZERO;
      end else begin
        cnt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_s = CNT_ZERO;
    end

    // Output is computed from next-cycle values so it is valid with the counter.
    if (state_s == ST_RUN) begin
      pwm_s = (cnt_s < act_duty_s);
    end else begin
      pwm_s = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= CNT_ZERO;
      burst_cnt_r  <= CNT_ZERO;
      sh_period_r  <= CNT_ZERO;
      sh_duty_r    <= CNT_ZERO;
      sh_burst_r   <= CNT_ZERO;
      sh_mode_r    <= MODE_OFF;
      act_period_r <= CNT_ZERO;
      act_duty_r   <= CNT_ZERO;
      act_burst_r  <= CNT_ZERO;
      act_mode_r   <= MODE_OFF;
      pwm_r        <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      burst_cnt_r  <= burst_cnt_s;
      sh_period_r  <= sh_period_s;
      sh_duty_r    <= sh_duty_s;
      sh_burst_r   <= sh_burst_s;
      sh_mode_r    <= sh_mode_s;
      act_period_r <= act_period_s;
      act_duty_r   <= act_duty_s;
      act_burst_r  <= act_burst_s;
      act_mode_r   <= act_mode_s;
      pwm_r        <= pwm_s;
      done_r       <= done_s;
    end
  end

  // Outputs straight from registers
  always_comb begin
    pwm_out = pwm_r;
    busy    = (state_r == ST_RUN);
    done    = done_r;
  end

endmodule

// File: rtl/pwm_array_gen.sv
// pwm_array_gen
// Array of NUM_CH independent PWM channels sharing one config bus.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN  clock, asynchronous active-low reset
//   cfg_we, cfg_ch, cfg_sel, cfg_wdata  shadow config write; cfg_ch >= NUM_CH ignored
//   start, stop                per-channel start / stop pulses
//   sync_in                    global phase-align pulse
//   pwm_out, busy, done        per-channel registered outputs
module pwm_array_gen
  import pwm_array_pkg::*;
#(
  parameter int unsigned NUM_CH        = 16,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic                     cfg_we,
  input  logic [4:0]               cfg_ch,
  input  logic [1:0]               cfg_sel,
  input  logic [COUNTER_WIDTH-1:0] cfg_wdata,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH-1:0]        stop,
  input  logic                     sync_in,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done
);

  logic [NUM_CH-1:0] ch_we_s;

  // Full-width channel compare, so out-of-range indices match no channel.
  always_comb begin
    ch_we_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (cfg_ch == CH_IDX_W'(i))) begin
        ch_we_s[i] = 1'b1;
      end else begin
        ch_we_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_array_chan #(
      .CW (COUNTER_WIDTH)
    ) u_chan (
      .clk       (S_AXI_ACLK),
      .rst_n     (S_AXI_ARESETN),
      .cfg_we    (ch_we_s[g]),
      .cfg_sel   (cfg_sel),
      .cfg_wdata (cfg_wdata),
      .start     (start[g]),
      .stop      (stop[g]),
      .sync_in   (sync_in),
      .pwm_out   (pwm_out[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

endmodule

// File: tb/tb_pwm_array_gen.sv
// tb_pwm_array_gen
// Scoreboard bench: expected {pwm,busy,done} per channel and cycle are queued
// when stimulus is driven and compared at the falling edge of the due cycle.
module tb_pwm_array_gen;

  localparam int NCH = 16;
  localparam int CW  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [4:0]      cfg_ch;
  logic [1:0]      cfg_sel;
  logic [CW-1:0]   cfg_wdata;
  logic [NCH-1:0]  start, stop;
  logic            sync_in;
  logic [NCH-1:0]  pwm_out, busy, done;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int         due;
    int         ch;
    logic [2:0] val;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t keep_q[$];

  pwm_array_gen #(.NUM_CH(NCH), .COUNTER_WIDTH(CW)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .cfg_we        (cfg_we),
    .cfg_ch        (cfg_ch),
    .cfg_sel       (cfg_sel),
    .cfg_wdata     (cfg_wdata),
    .start         (start),
    .stop          (stop),
    .sync_in       (sync_in),
    .pwm_out       (pwm_out),
    .busy          (busy),
    .done          (done)
  );

  // Clock
  always #5 clk = ~clk;

  // Cycle index: stimulus set in cycle c is seen by the DUT at the end of c
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
  endtask

  // Scoreboard: compare every entry due in this cycle, keep the rest
  always @(negedge clk) begin
    keep_q.delete();
    foreach (exp_q[i]) begin
      if (exp_q[i].due == cyc)
        check_eq($sformatf("%s c%0d ch%0d {pwm,busy,done}", exp_q[i].tag, cyc, exp_q[i].ch),
                 {29'd0, pwm_out[exp_q[i].ch], busy[exp_q[i].ch], done[exp_q[i].ch]},
                 {29'd0, exp_q[i].val});
      else
        keep_q.push_back(exp_q[i]);
    end
    exp_q = keep_q;
  end

  // Watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic cfg_write(input int ch, input logic [1:0] sel, input logic [31:0] data);
    cfg_we = 1'b1; cfg_ch = ch[4:0]; cfg_sel = sel; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_chan(input int ch, input int period, input int duty, input int blen, input int mode);
    cfg_write(ch, 2'd0, 32'(period));
    cfg_write(ch, 2'd1, 32'(duty));
    cfg_write(ch, 2'd2, 32'(blen));
    cfg_write(ch, 2'd3, 32'(mode));
  endtask

  task automatic pulse(input logic [NCH-1:0] st, input logic [NCH-1:0] sp, input logic sy);
    start = st; stop = sp; sync_in = sy;
    tick();
    start = '0; stop = '0; sync_in = 1'b0;
  endtask

  task automatic push_exp(input int due, input int ch, input logic [2:0] val, input string tag);
    exp_t e;
    e.due = due; e.ch = ch; e.val = val; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Running channel whose counter is 0 in cycle org+1: due org+d has counter (d-1)%period
  task automatic push_run(input int org, input int d0, input int d1, input int ch,
                          input int period, input int duty, input string tag);
    for (int d = d0; d <= d1; d++) begin
      int   k;
      logic p;
      k = (d - 1) % period;
      p = (k < duty);
      push_exp(org + d, ch, {p, 1'b1, 1'b0}, tag);
    end
  endtask

  task automatic push_idle(input int from, input int to, input int ch, input string tag);
    for (int c = from; c <= to; c++) push_exp(c, ch, 3'b000, tag);
  endtask

  // Stimulus
  initial begin
    int t, t2, t3, s, r;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = 5'd0; cfg_sel = 2'd0; cfg_wdata = 32'd0;
    start = '0; stop = '0; sync_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset pwm_out", 32'(pwm_out), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // ch0 continuous period 10 duty 3
    cfg_chan(0, 10, 3, 0, 1);
    t = cyc;
    push_exp(t, 0, 3'b000, "cont_pre");
    push_run(t, 1, 30, 0, 10, 3, "cont");
    pulse(16'h0001, 16'h0000, 1'b0);
    wait_cyc(t + 30);
    s = cyc;
    push_idle(s + 1, s + 2, 0, "cont_stop");
    pulse(16'h0000, 16'h0001, 1'b0);

    // out-of-range channel write must not alias onto ch0
    cfg_write(16, 2'd1, 32'd0);

    // ch0 duty change mid-period, then a write landing on the wrap cycle
    t2 = cyc;
    push_run(t2, 1, 10, 0, 10, 3, "shadow_p1");
    push_run(t2, 11, 20, 0, 10, 8, "shadow_p2");
    push_run(t2, 21, 30, 0, 10, 5, "shadow_p3");
    pulse(16'h0001, 16'h0000, 1'b0);
    wait_cyc(t2 + 5);
    cfg_write(0, 2'd1, 32'd8);
    wait_cyc(t2 + 20);
    cfg_write(0, 2'd1, 32'd5);
    wait_cyc(t2 + 30);
    push_idle(cyc + 1, cyc + 1, 0, "shadow_stop");
    pulse(16'h0000, 16'h0001, 1'b0);

    // ch1 burst: period 4, duty 2, 3 periods
    cfg_chan(1, 4, 2, 3, 2);
    t = cyc;
    push_run(t, 1, 12, 1, 4, 2, "burst");
    push_exp(t + 13, 1, 3'b001, "burst_done");
    push_idle(t + 14, t + 16, 1, "burst_after");
    pulse(16'h0002, 16'h0000, 1'b0);
    wait_cyc(t + 16);

    // ch1 restart while running resets counter and burst count
    t = cyc;
    push_run(t, 1, 6, 1, 4, 2, "restart_a");
    pulse(16'h0002, 16'h0000, 1'b0);
    wait_cyc(t + 6);
    t3 = cyc;
    push_run(t3, 1, 12, 1, 4, 2, "restart_b");
    push_exp(t3 + 13, 1, 3'b001, "restart_done");
    push_idle(t3 + 14, t3 + 15, 1, "restart_after");
    pulse(16'h0002, 16'h0000, 1'b0);
    wait_cyc(t3 + 15);

    // ch2/ch3 started 5 cycles apart, then sync
    cfg_chan(2, 8, 3, 0, 1);
    cfg_chan(3, 8, 3, 0, 1);
    t = cyc;
    push_run(t, 1, 10, 2, 8, 3, "sync_ch2");
    pulse(16'h0004, 16'h0000, 1'b0);
    wait_cyc(t + 5);
    push_run(t + 5, 1, 5, 3, 8, 3, "sync_ch3");
    pulse(16'h0008, 16'h0000, 1'b0);
    wait_cyc(t + 10);
    s = cyc;
    push_run(s, 1, 20, 2, 8, 3, "synced");
    push_run(s, 1, 20, 3, 8, 3, "synced");
    pulse(16'h0000, 16'h0000, 1'b1);
    wait_cyc(s + 20);
    push_idle(s + 21, s + 21, 2, "sync_stop");
    push_idle(s + 21, s + 21, 3, "sync_stop");
    pulse(16'h0000, 16'h000C, 1'b0);

    // ch4 start+stop together; ch5 duty 0; ch6 duty>period; ch7 period 0; ch8 zero burst
    cfg_chan(4, 5, 2, 0, 1);
    t = cyc;
    push_idle(t + 1, t + 3, 4, "start_stop");
    pulse(16'h0010, 16'h0010, 1'b0);
    cfg_chan(5, 10, 0, 0, 1);
    cfg_chan(6, 10, 20, 0, 1);
    cfg_chan(7, 0, 3, 0, 1);
    cfg_chan(8, 5, 2, 0, 2);
    t = cyc;
    push_run(t, 1, 15, 5, 10, 0, "duty0");
    push_run(t, 1, 15, 6, 10, 20, "duty_full");
    push_idle(t + 1, t + 4, 7, "period0");
    push_exp(t + 1, 8, 3'b001, "burst0_done");
    push_idle(t + 2, t + 4, 8, "burst0_after");
    pulse(16'h01E0, 16'h0000, 1'b0);
    wait_cyc(t + 15);
    push_idle(t + 16, t + 16, 5, "duty0_stop");
    push_idle(t + 16, t + 16, 6, "duty_full_stop");
    pulse(16'h0000, 16'h0060, 1'b0);

    // reset in the middle of a ch1 burst
    t = cyc;
    push_run(t, 1, 4, 1, 4, 2, "pre_reset");
    pulse(16'h0002, 16'h0000, 1'b0);
    wait_cyc(t + 5);
    rst_n = 1'b0;
    #1;
    check_eq("async reset pwm_out", 32'(pwm_out), 32'd0);
    check_eq("async reset busy", 32'(busy), 32'd0);
    check_eq("async reset done", 32'(done), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    r = cyc;
    push_idle(r + 1, r + 15, 0, "post_reset");
    push_idle(r + 1, r + 15, 1, "post_reset");
    pulse(16'h0003, 16'h0000, 1'b0);
    wait_cyc(r + 16);
    check_eq("post reset busy", 32'(busy), 32'd0);
    check_eq("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_array_gen.md
PWM_ARRAY_GEN -- requirements
Module: pwm_array_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, number of independent PWM channels (1..32).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 32, width of period/duty/burst fields.
REQ-003 SHALL have port S_AXI_ACLK, input, 1 bit, single clock for all logic; one clock only.
REQ-004 SHALL have port S_AXI_ARESETN, input, 1 bit, reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_we, input, 1 bit, config write strobe.
REQ-006 SHALL have port cfg_ch, input, 5 bits, target channel; values >= NUM_CH ignored.
REQ-007 SHALL have port cfg_sel, input, 2 bits, field select: 0 period, 1 duty, 2 burst_len, 3 mode.
REQ-008 SHALL have port cfg_wdata, input, COUNTER_WIDTH bits, write data; mode uses bits [1:0].
REQ-009 SHALL have port start, input, NUM_CH bits, per-channel start pulse.
REQ-010 SHALL have port stop, input, NUM_CH bits, per-channel stop pulse.
REQ-011 SHALL have port sync_in, input, 1 bit, global phase-align pulse.
REQ-012 SHALL have port pwm_out, output, NUM_CH bits, registered PWM outputs.
REQ-013 SHALL have port busy, output, NUM_CH bits, channel in RUN state.
REQ-014 SHALL have port done, output, NUM_CH bits, one-cycle pulse at burst completion.

Function
REQ-015 Each channel SHALL hold shadow and active copies of period, duty, burst_len, mode; cfg_we writes shadow only.
REQ-016 Shadow SHALL copy to active on start, and on each period wrap while running; no mid-period change.
REQ-017 Per-channel FSM states: IDLE, RUN; IDLE->RUN on start, RUN->IDLE on stop, burst end, or active mode OFF at wrap.
REQ-018 Mode encoding: 0 OFF, 1 CONTINUOUS, 2 BURST, 3 reserved treated as OFF; start with shadow mode OFF keeps IDLE.
REQ-019 In RUN, counter SHALL count 0..period-1 then wrap to 0; pwm_out = (counter < duty), registered.
REQ-020 Latency: start in cycle t -> counter=0 and pwm_out valid in cycle t+1.
REQ-021 duty=0 -> pwm_out constant low; duty>=period -> constant high; period=0 -> start ignored, channel stays IDLE.
REQ-022 BURST: channel SHALL run exactly burst_len complete periods, then IDLE; done pulses in the cycle pwm_out first reads low in IDLE.
REQ-023 burst_len=0 in BURST: start SHALL produce done pulse at t+1, busy never asserted, pwm_out low.
REQ-024 Period counter comparisons SHALL be unsigned, COUNTER_WIDTH bits; burst counter SHALL saturate, never wrap.
REQ-025 In IDLE, pwm_out SHALL be low and counter held at 0.
REQ-026 stop and start on same channel same cycle: stop wins, channel IDLE at t+1, no done pulse.
REQ-027 start while already RUN: SHALL restart at counter 0 with shadow reloaded, burst count reset.
REQ-028 sync_in SHALL zero the counter of every RUN channel next cycle, without reloading config or advancing burst count.
REQ-029 sync_in coincident with a wrap: wrap reload occurs, burst count advances once.
REQ-030 stop SHALL never produce done; done only on natural burst completion.
REQ-031 cfg_we in same cycle as wrap: new value SHALL be taken at that wrap.

Reset
REQ-032 On S_AXI_ARESETN low, asynchronously: all channels IDLE, pwm_out/busy/done = 0, counters 0.
REQ-033 Reset values: shadow and active period=0, duty=0, burst_len=0, mode=OFF.
REQ-034 Reset asserted mid-burst SHALL abort without done pulse; operation resumes only on new start after release.

Structure
REQ-035 Package pwm_array_pkg SHALL hold mode encoding constants, cfg_sel field codes, and FSM state encoding.
REQ-036 One sub-module pwm_array_chan SHALL implement a single channel (shadow/active regs, counter, FSM); top instantiates NUM_CH copies and decodes cfg_ch.

Verification
REQ-037 ch0 period=10, duty=3, CONTINUOUS, start -> pwm_out[0] high 3 cycles, low 7, repeating, from t+1.
REQ-038 ch1 period=4, duty=2, BURST burst_len=3, start -> exactly 3 pulses, busy 12 cycles, done[1] one-cycle pulse after.
REQ-039 ch0 running period=10 duty=3; write duty=8 mid-period -> current period keeps 3 high, next period 8 high.
REQ-040 ch2, ch3 started 5 cycles apart, period=8; sync_in -> both counters 0 next cycle, outputs identical thereafter.
REQ-041 start and stop same cycle on ch4 -> busy stays 0, no done; duty=0 and duty=20/period=10 -> constant low/high.
REQ-042 Assert S_AXI_ARESETN low mid-burst on ch1 -> all outputs 0 immediately, no done; config reads back reset values via behaviour.
